// File: rtl/add16_twos_comp_if.sv
// Operand/result bundle for the 16-bit two's-complement adder/subtractor.
// The master drives the operands and the slave returns the registered result and flags.
interface add16_twos_comp_if;
   logic        Op;
   logic        Cin;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] S;
   logic        Cout;
   logic        V;
   logic        Z;
   logic        N;

   modport master (
      output Op, Cin, A, B,
      input  S, Cout, V, Z, N
   );

   modport slave (
      input  Op, Cin, A, B,
      output S, Cout, V, Z, N
   );
endinterface

// File: rtl/add16_twos_comp.sv
// Registered 16-bit ripple-carry adder/subtractor with carry and optional V/Z/N flags.
// The flags are computed only when ADD16_FLAGS_EN is defined; otherwise V/Z/N are tied to 0.
module add16_twos_comp (
   input  logic                clk,
   input  logic                rst_n,
   add16_twos_comp_if.slave    bus
);
   logic [15:0] bx;
   logic [16:0] carry;
   logic [15:0] sum;
   logic [15:0] s_reg;
   logic        cout_reg;

   // Subtraction is A + ~B + ~Cin, so the borrow-in is inverted along with B.
   assign bx       = bus.B ^ {16{bus.Op}};
   assign carry[0] = bus.Cin ^ bus.Op;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_fa
         assign sum[gi]      = bus.A[gi] ^ bx[gi] ^ carry[gi];
         assign carry[gi+1]  = (bus.A[gi] & bx[gi]) | (carry[gi] & (bus.A[gi] ^ bx[gi]));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg    <= 16'h0000;
         cout_reg <= 1'b0;
      end else begin
         s_reg    <= sum;
         cout_reg <= carry[16];
      end
   end

   assign bus.S    = s_reg;
   assign bus.Cout = cout_reg;

`ifdef ADD16_FLAGS_EN
   logic v_reg;
   logic z_reg;
   logic n_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_reg <= 1'b0;
         z_reg <= 1'b0;
         n_reg <= 1'b0;
      end else begin
         v_reg <= carry[15] ^ carry[16];
         z_reg <= (sum == 16'h0000);
         n_reg <= sum[15];
      end
   end

   assign bus.V = v_reg;
   assign bus.Z = z_reg;
   assign bus.N = n_reg;
`else
   assign bus.V = 1'b0;
   assign bus.Z = 1'b0;
   assign bus.N = 1'b0;
`endif
endmodule

// File: tb/tb_add16_twos_comp.sv
// Directed and random checks of add16_twos_comp against an integer-arithmetic scoreboard.
module tb_add16_twos_comp;
   logic clk;
   logic rst_n;
   int   passed;
   int   total;

`ifdef ADD16_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct {
      logic [15:0] s;
      logic        cout;
      logic        v;
      logic        z;
      logic        n;
   } exp_t;

   exp_t sb[$];

   add16_twos_comp_if bus ();

   add16_twos_comp dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   function automatic exp_t model(input logic op, input logic cin,
                                  input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   ua, ub, uc, ur, sa, sb_i, sr;
      ua   = int'(a);
      ub   = int'(b);
      uc   = int'(cin);
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
      if (!op) begin
         ur     = ua + ub + uc;
         sr     = sa + sb_i + uc;
         e.cout = (ur > 65535);
      end else begin
         ur     = ua - ub - uc;
         sr     = sa - sb_i - uc;
         e.cout = (ur >= 0);
      end
      e.s = ur[15:0];
      e.v = FLAGS & ((sr > 32767) || (sr < -32768));
      e.z = FLAGS & (e.s == 16'h0000);
      e.n = FLAGS & e.s[15];
      return e;
   endfunction

   task automatic check_out(input string tag, input exp_t e);
      check({tag, ".S"},    bus.S,           e.s);
      check({tag, ".Cout"}, {15'd0, bus.Cout}, {15'd0, e.cout});
      check({tag, ".V"},    {15'd0, bus.V},    {15'd0, e.v});
      check({tag, ".Z"},    {15'd0, bus.Z},    {15'd0, e.z});
      check({tag, ".N"},    {15'd0, bus.N},    {15'd0, e.n});
   endtask

   // Drive at the falling edge, capture at the next rising edge, compare 1 time unit later.
   task automatic step(input string tag, input logic op, input logic cin,
                       input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      @(negedge clk);
      bus.Op  = op;
      bus.Cin = cin;
      bus.A   = a;
      bus.B   = b;
      sb.push_back(model(op, cin, a, b));
      @(posedge clk);
      #1;
      total++;
      assert (sb.size() == 1) passed++;
      else $error("FAIL %s.queue observed=%0d expected=1", tag, sb.size());
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_out(tag, e);
         $display("%s op=%0d cin=%0d a=%h b=%h -> S=%h Cout=%0d V=%0d Z=%0d N=%0d",
                  tag, op, cin, a, b, bus.S, bus.Cout, bus.V, bus.Z, bus.N);
      end
   endtask

   exp_t zero_e;
   exp_t fixed_e;

   initial begin
      passed   = 0;
      total    = 0;
      zero_e   = '{s: 16'h0000, cout: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
      rst_n    = 1'b0;
      bus.Op   = 1'b0;
      bus.Cin  = 1'b0;
      bus.A    = 16'h0;
      bus.B    = 16'h0;

      repeat (2) @(posedge clk);
      #1;
      check_out("reset", zero_e);
      @(negedge clk);
      rst_n = 1'b1;

      // Known-answer vectors.
      step("ovf_wrap",  1'b0, 1'b1, 16'hFFFF, 16'h0001);
      step("pos_ovf",   1'b0, 1'b0, 16'h7FFF, 16'h0001);
      step("sub_borr",  1'b1, 1'b0, 16'h1234, 16'h4321);
      step("sub_noborr",1'b1, 1'b1, 16'h4321, 16'h1234);
      step("add_zero",  1'b0, 1'b1, 16'h5555, 16'hAAAA);
      step("add_ones",  1'b0, 1'b0, 16'hAAAA, 16'h5555);
      step("sub_ovf",   1'b1, 1'b0, 16'h8000, 16'h0001);
      step("wrap_nc",   1'b0, 1'b0, 16'hFFFF, 16'h0001);
      step("sub_self",  1'b1, 1'b0, 16'hBEEF, 16'hBEEF);

      // Absolute expectations for the known-answer cases above, independent of the model.
      fixed_e = model(1'b1, 1'b1, 16'h4321, 16'h1234);
      check("kat.sub_noborr.S", fixed_e.s, 16'h30EC);

      // Asynchronous reset between edges discards the pending result.
      @(negedge clk);
      bus.Op  = 1'b0;
      bus.Cin = 1'b0;
      bus.A   = 16'h1234;
      bus.B   = 16'h4321;
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", zero_e);
      @(posedge clk);
      #1;
      check_out("rst_hold", zero_e);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_out("rst_release", zero_e);
      @(posedge clk);
      #1;
      check("post_rst.S", bus.S, 16'h5555);
      check_out("post_rst", model(1'b0, 1'b0, 16'h1234, 16'h4321));
      $display("post_rst a=1234 b=4321 -> S=%h Cout=%0d", bus.S, bus.Cout);

      for (int i = 0; i < 1000; i++) begin
         step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Absolute guard against a stalled run.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/add16_twos_comp.md
ADD16_TWOS_COMP -- requirements
Module: add16_twos_comp

Interface
REQ-001 Parameter: none; datapath width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Op  input  1  operation select: 0 = add, 1 = subtract.
REQ-005 Cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-006 A  input  16  operand A, unsigned or two's complement.
REQ-007 B  input  16  operand B, unsigned or two's complement.
REQ-008 S  output  16  registered sum/difference.
REQ-009 Cout  output  1  registered carry-out (add) / not-borrow (subtract).
REQ-010 V  output  1  registered signed-overflow flag.
REQ-011 Z  output  1  registered zero flag.
REQ-012 N  output  1  registered negative flag (copy of S[15]).

Function
REQ-013 Internal operand SHALL be Bx = B XOR {16{Op}}; internal carry-in SHALL be ci = Cin XOR Op.
REQ-014 Internal 17-bit result SHALL be R = {0,A} + {0,Bx} + ci, computed as a 16-stage ripple chain of full-adder cells.
REQ-015 Op=0: S SHALL equal (A + B + Cin) mod 2^16; Cout SHALL equal R[16].
REQ-016 Op=1: S SHALL equal (A - B - Cin) mod 2^16; Cout SHALL equal R[16] (1 = no borrow, 0 = borrow).
REQ-017 V SHALL equal carry into bit 15 XOR carry out of bit 15 of the chain.
REQ-018 Z SHALL be 1 iff R[15:0] == 0; N SHALL equal R[15].
REQ-019 Latency SHALL be exactly one clock: inputs sampled at edge k appear on S/Cout/V/Z/N after edge k; outputs SHALL hold between edges.
REQ-020 No handshake; a new operation SHALL be accepted every cycle.
REQ-021 Wrap-around SHALL be silent modulo 2^16 (e.g. FFFF+0001 -> 0000, Cout=1).
REQ-022 Inputs SHALL have no combinational path to any output.

Reset
REQ-023 rst_n low SHALL immediately force S=0000, Cout=0, V=0, Z=0, N=0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL discard the pending result; first valid result SHALL appear one edge after rst_n deasserts.
REQ-025 Reset deassertion SHALL take effect at the next rising edge only.

Configuration
REQ-026 Macro ADD16_FLAGS_EN defined: V, Z, N SHALL be computed and registered per REQ-017/018.
REQ-027 Macro ADD16_FLAGS_EN undefined: V, Z, N ports SHALL remain present and be driven constant 0; S/Cout behaviour SHALL be unchanged.

Verification
REQ-028 Op=0, A=FFFF, B=0001, Cin=1 -> after 1 edge S=0001, Cout=1, V=0, Z=0.
REQ-029 Op=0, A=7FFF, B=0001, Cin=0 -> S=8000, Cout=0, V=1, N=1.
REQ-030 Op=1, A=1234, B=4321, Cin=0 -> S=CF13, Cout=0 (borrow), N=1; Op=1, A=4321, B=1234, Cin=1 -> S=30EC, Cout=1.
REQ-031 Op=0, A=5555, B=AAAA, Cin=1 -> S=0000, Cout=1, Z=1; Op=0, A=AAAA, B=5555, Cin=0 -> S=FFFF, Cout=0.
REQ-032 Op=1, A=8000, B=0001, Cin=0 -> S=7FFF, Cout=1, V=1.
REQ-033 Drive A=1234, B=4321, Op=0; assert rst_n low between edges -> outputs 0 at once; release -> S=5555 one edge later; plus 1000 random (A,B,Op,Cin) vectors checked against REQ-015/016 with one-cycle delay.
